// File: rtl/gcd_ctrl_pkg.sv
// Shared types and defaults for the GCD job sequencer.
package gcd_ctrl_pkg;

    localparam int CNT_W_DEF      = 32;
    localparam int CLR_CYCLES_DEF = 2;

    // Job phases; every strobe is decoded directly from this state.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_CAPTURE,
        S_FLUSH
    } state_t;

    // Completion code reported to software through the STATUS register.
    typedef enum logic [1:0] {
        ST_NONE    = 2'b00,
        ST_OK      = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_ABORT   = 2'b11
    } status_t;

endpackage

// File: rtl/gcd_job_sequencer_if.sv
// Command/status and core-control signals between the register bank,
// the GCD core and the job sequencer.
interface gcd_job_sequencer_if
    import gcd_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             CMD_START;
    logic             CMD_ABORT;
    logic             IRQ_CLEAR;
    logic [CNT_W-1:0] TIMEOUT_LIMIT;
    logic             DONE;

    logic             ARGS_LOAD;
    logic             CORE_CLEAR;
    logic             CORE_START;
    logic             RESULT_CAPTURE;
    logic             BUSY;
    logic [1:0]       STATUS;
    logic [CNT_W-1:0] CYCLE_COUNT;
    logic             IRQ;

    // Register bank / core side: issues commands, observes strobes.
    modport master (
        output CMD_START, CMD_ABORT, IRQ_CLEAR, TIMEOUT_LIMIT, DONE,
        input  ARGS_LOAD, CORE_CLEAR, CORE_START, RESULT_CAPTURE,
        input  BUSY, STATUS, CYCLE_COUNT, IRQ
    );

    // Sequencer side.
    modport slave (
        input  CMD_START, CMD_ABORT, IRQ_CLEAR, TIMEOUT_LIMIT, DONE,
        output ARGS_LOAD, CORE_CLEAR, CORE_START, RESULT_CAPTURE,
        output BUSY, STATUS, CYCLE_COUNT, IRQ
    );

endinterface

// File: rtl/gcd_job_sequencer.sv
// Sequences one GCD job per software command: load args, clear core,
// start it, wait for DONE / timeout / abort, then capture or flush.
module gcd_job_sequencer
    import gcd_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
    input logic                CLK,
    input logic                RESET,
    gcd_job_sequencer_if.slave bus
);

    localparam int               CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    state_t           state;
    status_t          status;
    logic [CNT_W-1:0] cycle_count;
    logic             irq;
    logic [CLR_W-1:0] clr_cnt;
    logic             first_run;

    // DONE is a level that may still be high from the previous job, so it
    // is only trusted from the second RUN cycle on.
    logic done_ok;
    logic timeout_hit;
    logic irq_set;

    assign done_ok     = (state == S_RUN) && bus.DONE && !first_run;
    assign timeout_hit = (bus.TIMEOUT_LIMIT != '0) && (cycle_count == bus.TIMEOUT_LIMIT);
    assign irq_set     = (state == S_CAPTURE) || ((state == S_FLUSH) && (clr_cnt == '0));

    // Strobes come straight from the state register, no extra cycle.
    assign bus.ARGS_LOAD      = (state == S_LOAD);
    assign bus.CORE_CLEAR     = (state == S_CLEAR) || (state == S_FLUSH);
    assign bus.CORE_START     = (state == S_RUN) && first_run;
    assign bus.RESULT_CAPTURE = (state == S_CAPTURE);
    assign bus.BUSY           = (state != S_IDLE);
    assign bus.STATUS         = status;
    assign bus.CYCLE_COUNT    = cycle_count;
    assign bus.IRQ            = irq;

    // Job FSM with its counters and sticky completion flags.
    // NOTE: every register here uses <= so all updates see the pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            status      <= ST_NONE;
            cycle_count <= '0;
            irq         <= 1'b0;
            clr_cnt     <= '0;
            first_run   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.CMD_START) begin
                        state       <= S_LOAD;
                        status      <= ST_NONE;
                        cycle_count <= '0;
                    end
                end
                S_LOAD: begin
                    clr_cnt <= CLR_LAST;
                    if (bus.CMD_ABORT) begin
                        state  <= S_FLUSH;
                        status <= ST_ABORT;
                    end else begin
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (bus.CMD_ABORT) begin
                        state   <= S_FLUSH;
                        status  <= ST_ABORT;
                        clr_cnt <= CLR_LAST;
                    end else if (clr_cnt == '0) begin
                        state     <= S_RUN;
                        first_run <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    first_run <= 1'b0;
                    if (done_ok) begin
                        state <= S_CAPTURE;
                    end else begin
                        if (!timeout_hit && (cycle_count != '1)) begin
                            cycle_count <= cycle_count + 1'b1;
                        end
                        if (bus.CMD_ABORT) begin
                            state   <= S_FLUSH;
                            status  <= ST_ABORT;
                            clr_cnt <= CLR_LAST;
                        end else if (timeout_hit) begin
                            state   <= S_FLUSH;
                            status  <= ST_TIMEOUT;
                            clr_cnt <= CLR_LAST;
                        end
                    end
                end
                S_CAPTURE: begin
                    status <= ST_OK;
                    state  <= S_IDLE;
                end
                S_FLUSH: begin
                    if (clr_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Completion beats a coincident clear so no interrupt is lost.
            if (irq_set) begin
                irq <= 1'b1;
            end else if (bus.IRQ_CLEAR || ((state == S_IDLE) && bus.CMD_START)) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer: a cycle table for the normal job and
// hygiene checks, then hand-written sequences for timeout, abort and reset.
module tb_gcd_job_sequencer;
    import gcd_ctrl_pkg::*;

    logic CLK;
    logic RESET;

    gcd_job_sequencer_if #(.CNT_W(32)) bus ();

    gcd_job_sequencer #(.CNT_W(32), .CLR_CYCLES(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total  = 0;
    int n_passed = 0;

    // Flag layout: {ARGS_LOAD, CORE_CLEAR, CORE_START, RESULT_CAPTURE, BUSY, STATUS[1:0], IRQ}
    typedef struct {
        logic        start;
        logic        abort;
        logic        irq_clr;
        logic        done;
        logic [7:0]  exp_flags;
        logic [31:0] exp_count;
    } vec_t;

    vec_t        vecs[18];
    logic [7:0]  obs_flags[32];
    logic [31:0] obs_count[32];

    function automatic logic [7:0] flags();
        return {bus.ARGS_LOAD, bus.CORE_CLEAR, bus.CORE_START, bus.RESULT_CAPTURE,
                bus.BUSY, bus.STATUS, bus.IRQ};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_passed++;
    endtask

    task automatic drive(input logic s, input logic a, input logic ic, input logic d);
        bus.CMD_START = s;
        bus.CMD_ABORT = a;
        bus.IRQ_CLEAR = ic;
        bus.DONE      = d;
    endtask

    // Outputs are observed 1 time unit after the edge, then inputs for that
    // cycle are applied and sampled at the next edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Start at cycle 0; abort/done/reset asserted on the given cycles (-1 = never).
    task automatic run_seq(input int n, input int abort_at, input int done_from,
                           input int done_only, input int reset_at);
        for (int c = 0; c < n; c++) begin
            obs_flags[c] = flags();
            obs_count[c] = bus.CYCLE_COUNT;
            drive(c == 0, c == abort_at, 1'b0,
                  ((done_from >= 0) && (c >= done_from)) || (c == done_only));
            RESET = (c == reset_at);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
    endtask

    function automatic logic any_capture(input int n);
        logic seen = 1'b0;
        for (int c = 0; c < n; c++) seen |= obs_flags[c][4];
        return seen;
    endfunction

    initial begin
        // Normal job, DONE from 14; CMD_START at 6 while busy; IRQ_CLEAR
        // coincident with the IRQ set at 15 and again at 16.
        for (int i = 0; i < 18; i++) begin
            vecs[i] = '{start: 1'b0, abort: 1'b0, irq_clr: 1'b0, done: 1'b0,
                        exp_flags: 8'b0000_1000, exp_count: 32'(i > 4 ? i - 4 : 0)};
        end
        vecs[0].start      = 1'b1;
        vecs[0].exp_flags  = 8'b0000_0000;
        vecs[1].exp_flags  = 8'b1000_1000;
        vecs[2].exp_flags  = 8'b0100_1000;
        vecs[3].exp_flags  = 8'b0100_1000;
        vecs[4].exp_flags  = 8'b0010_1000;
        vecs[6].start      = 1'b1;
        vecs[14].done      = 1'b1;
        vecs[15].done      = 1'b1;
        vecs[15].irq_clr   = 1'b1;
        vecs[15].exp_flags = 8'b0001_1000;
        vecs[15].exp_count = 32'd10;
        vecs[16].irq_clr   = 1'b1;
        vecs[16].exp_flags = 8'b0000_0011;
        vecs[16].exp_count = 32'd10;
        vecs[17].exp_flags = 8'b0000_0010;
        vecs[17].exp_count = 32'd10;

        RESET             = 1'b1;
        bus.TIMEOUT_LIMIT = '0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        RESET = 1'b0;
        check("reset_flags", 32'(flags()), 32'h0);
        check("reset_count", bus.CYCLE_COUNT, 32'd0);

        for (int i = 0; i < 18; i++) begin
            check($sformatf("normal_flags_c%0d", i), 32'(flags()), 32'(vecs[i].exp_flags));
            check($sformatf("normal_count_c%0d", i), bus.CYCLE_COUNT, vecs[i].exp_count);
            drive(vecs[i].start, vecs[i].abort, vecs[i].irq_clr, vecs[i].done);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Timeout after 5 RUN cycles.
        bus.TIMEOUT_LIMIT = 32'd5;
        run_seq(14, -1, -1, -1, -1);
        check("to_run9_count", obs_count[9], 32'd5);
        check("to_flush10",    32'(obs_flags[10]), 32'h4C);
        check("to_flush11",    32'(obs_flags[11]), 32'h4C);
        check("to_idle12",     32'(obs_flags[12]), 32'h05);
        check("to_count12",    obs_count[12], 32'd5);
        check("to_no_capture", 32'(any_capture(14)), 32'd0);

        // Abort in RUN; start also clears the IRQ and STATUS left by the timeout.
        bus.TIMEOUT_LIMIT = '0;
        run_seq(11, 7, -1, -1, -1);
        check("ab_pre_start", 32'(obs_flags[0]), 32'h05);
        check("ab_load_clr",  32'(obs_flags[1]), 32'h88);
        check("ab_run7",      32'(obs_flags[7]), 32'h08);
        check("ab_flush8",    32'(obs_flags[8]), 32'h4E);
        check("ab_flush9",    32'(obs_flags[9]), 32'h4E);
        check("ab_idle10",    32'(obs_flags[10]), 32'h07);
        check("ab_count10",   obs_count[10], 32'd4);

        // Abort in CLEAR.
        run_seq(6, 2, -1, -1, -1);
        check("abc_clear2",  32'(obs_flags[2]), 32'h48);
        check("abc_flush3",  32'(obs_flags[3]), 32'h4E);
        check("abc_flush4",  32'(obs_flags[4]), 32'h4E);
        check("abc_idle5",   32'(obs_flags[5]), 32'h07);
        check("abc_count5",  obs_count[5], 32'd0);

        // DONE and CMD_ABORT together: DONE wins.
        run_seq(12, 9, 9, -1, -1);
        check("pri_run9_count", obs_count[9], 32'd5);
        check("pri_capture10",  32'(obs_flags[10]), 32'h18);
        check("pri_idle11",     32'(obs_flags[11]), 32'h03);
        check("pri_count11",    obs_count[11], 32'd5);

        // DONE only in the first RUN cycle is ignored; times out at 3.
        bus.TIMEOUT_LIMIT = 32'd3;
        run_seq(11, -1, -1, 4, -1);
        check("stale_start4",      32'(obs_flags[4]), 32'h28);
        check("stale_run7_count",  obs_count[7], 32'd3);
        check("stale_flush8",      32'(obs_flags[8]), 32'h4C);
        check("stale_idle10",      32'(obs_flags[10]), 32'h05);
        check("stale_count10",     obs_count[10], 32'd3);
        check("stale_no_capture",  32'(any_capture(11)), 32'd0);

        // Reset mid-RUN, then a clean job to completion.
        bus.TIMEOUT_LIMIT = '0;
        run_seq(10, -1, -1, -1, 8);
        check("rst_run8",   32'(obs_flags[8]), 32'h08);
        check("rst_count8", obs_count[8], 32'd4);
        check("rst_idle9",  32'(obs_flags[9]), 32'h00);
        check("rst_count9", obs_count[9], 32'd0);
        run_seq(17, -1, 14, -1, -1);
        check("post_load1",    32'(obs_flags[1]), 32'h88);
        check("post_start4",   32'(obs_flags[4]), 32'h28);
        check("post_capture",  32'(obs_flags[15]), 32'h18);
        check("post_idle16",   32'(obs_flags[16]), 32'h03);
        check("post_count16",  obs_count[16], 32'd10);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
Control FSM that sequences one GCD computation per software command: latch arguments, clear the core, start it, wait for DONE with optional timeout or abort, then capture results.
Sits between the SRAM-mapped register bank (CMD/STATUS registers) and the GCD core.
It drives only enables and strobes; the wide ARG/BEZOUT/DEBUG data stays in the register bank.

Parameters:
CNT_W, 32, width of cycle counter and timeout limit
CLR_CYCLES, 2, cycles CORE_CLEAR is held (>=1)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
CMD_START  in  1  one-cycle start command from register bank
CMD_ABORT  in  1  one-cycle abort command
IRQ_CLEAR  in  1  one-cycle write-1-to-clear of IRQ
TIMEOUT_LIMIT  in  CNT_W  max RUN cycles; 0 = timeout disabled
DONE  in  1  GCD core done (level)
ARGS_LOAD  out  1  register bank latches ARG_A/ARG_B into core-facing regs
CORE_CLEAR  out  1  active-high clear of GCD core state
CORE_START  out  1  one-cycle start pulse to GCD core
RESULT_CAPTURE  out  1  register bank snapshots BEZOUT_*/DEBUG_*
BUSY  out  1  job in progress
STATUS  out  2  00 none/pending, 01 ok, 10 timeout, 11 aborted
CYCLE_COUNT  out  CNT_W  RUN cycles consumed by last/current job
IRQ  out  1  sticky completion interrupt

Behaviour:
- One clock, CLK; RESET is synchronous and active-high.
- RESET sampled high: state IDLE; all strobes 0; BUSY 0, STATUS 00, CYCLE_COUNT 0, IRQ 0.
  - Applies mid-job too; no completion is reported.
- States: IDLE, LOAD, CLEAR, RUN, CAPTURE, FLUSH. Strobes are decoded from state register (no extra latency).
- IDLE:
  - CMD_START -> LOAD. On acceptance STATUS<=00, IRQ<=0, CYCLE_COUNT<=0.
  - CMD_ABORT ignored. CMD_START with CMD_ABORT in the same cycle: start accepted.
- LOAD: ARGS_LOAD=1 for exactly 1 cycle -> CLEAR.
- CLEAR: CORE_CLEAR=1 for CLR_CYCLES cycles (down-counter) -> RUN.
- RUN:
  - CORE_START=1 in the first RUN cycle only.
  - DONE is ignored in the first RUN cycle (stale-level guard).
  - Each RUN cycle without an accepted DONE and without timeout: CYCLE_COUNT += 1, saturating at all-ones.
  - Priority, highest first:
    1. DONE (not first cycle) -> CAPTURE.
    2. CMD_ABORT -> FLUSH, STATUS<=11.
    3. TIMEOUT_LIMIT!=0 and CYCLE_COUNT==TIMEOUT_LIMIT -> FLUSH, STATUS<=10.
- CMD_ABORT in LOAD or CLEAR -> FLUSH, STATUS<=11.
- CAPTURE: RESULT_CAPTURE=1 for 1 cycle; STATUS<=01, IRQ<=1 -> IDLE. CMD_ABORT ignored here.
- FLUSH: CORE_CLEAR=1 for CLR_CYCLES cycles; IRQ<=1 on exit -> IDLE.
- BUSY = (state != IDLE).
- CMD_START while BUSY: ignored, not queued.
- IRQ:
  - Sticky; cleared by IRQ_CLEAR or an accepted CMD_START.
  - IRQ set and IRQ_CLEAR in the same cycle: set wins.
- Latency, CMD_START at cycle t:
  - ARGS_LOAD at t+1
  - CORE_CLEAR at t+2 .. t+1+CLR_CYCLES
  - CORE_START at t+2+CLR_CYCLES
- TIMEOUT_LIMIT is sampled live each RUN cycle. Software must not change it mid-job; there is no hardware protection.

Decomposition:
- Shared package gcd_ctrl_pkg:
  - state enum
  - STATUS codes (ST_NONE, ST_OK, ST_TIMEOUT, ST_ABORT)
  - default CNT_W and CLR_CYCLES
- No sub-module. The saturating counter and the clear down-counter are inline. Single module, ~150-200 lines.

Test Plan:
1. Normal job (CLR_CYCLES=2, TIMEOUT_LIMIT=0): CMD_START at cycle 0; DONE high from cycle 14 ->
   - ARGS_LOAD @1, CORE_CLEAR @2-3, CORE_START @4
   - RESULT_CAPTURE @15
   - cycle 16: BUSY=0, STATUS=01, IRQ=1, CYCLE_COUNT=10
2. Timeout: TIMEOUT_LIMIT=5, DONE never ->
   - FLUSH entered @10, CORE_CLEAR @10-11
   - IDLE @12 with STATUS=10, IRQ=1, CYCLE_COUNT=5
   - no RESULT_CAPTURE
3. Abort: CMD_ABORT @7 (in RUN) -> CORE_CLEAR @8-9, STATUS=11, IRQ=1; repeat with abort @2 (CLEAR): same FLUSH, CYCLE_COUNT=0.
4. Priority: DONE and CMD_ABORT both high @9 -> CAPTURE, STATUS=01. DONE high only @4 (first RUN cycle) with TIMEOUT_LIMIT=3 -> ignored, times out, STATUS=10.
5. Command hygiene:
   - CMD_START @6 while BUSY -> no effect.
   - IRQ_CLEAR coincident with IRQ set -> IRQ=1; IRQ_CLEAR next cycle -> IRQ=0.
   - New CMD_START clears IRQ and STATUS.
6. RESET high @8 during RUN -> next cycle: all outputs at reset values, state IDLE; subsequent CMD_START runs a normal job to completion.
